booth_seq_mult: RTL and testbench
=================================

// Module: booth_seq_mult
// PURPOSE
//  Parametrised multi-cycle radix-2 Booth multiplier, the successor to the unrolled 8x8 array.
//  Computes the WIDTH x WIDTH product in signed or unsigned mode, performing STEPS Booth
//  steps per clock. Uses valid/ready handshakes on both sides; sits behind the ALU issue stage.
// PARAMETERS
//  WIDTH   8   operand width in bits (>=2); the product is 2*WIDTH bits
//  STEPS   1   Booth steps per clock (1..WIDTH+1)
// PORTS
//  clk        in   1        single clock; all state changes on its rising edge
//  rst        in   1        synchronous reset, active-high
//  in_valid   in   1        operands and mode are valid
//  in_ready   out  1        block can accept operands (high only in IDLE)
//  is_signed  in   1        1: two's-complement operands; 0: unsigned operands
//  a          in   WIDTH    multiplicand M
//  b          in   WIDTH    multiplier Q
//  out_valid  out  1        product is valid (high only in DONE)
//  out_ready  in   1        consumer accepts the product
//  z          out  2*WIDTH  product
// BEHAVIOUR
//  - Reset (rst=1 at a clock edge): state<=IDLE; in_ready=1, out_valid=0, z=0; internal A/Q/count
//    are cleared. Reset mid-RUN or mid-DONE aborts the operation and no result is produced.
//  - Internal width is N=WIDTH+1. a and b are extended to N bits: sign-extended if is_signed=1,
//    zero-extended otherwise. Registers: M[N], A[N], Q[N], q_m1 (1 bit), step count.
//  - States:
//    - IDLE: in_ready=1. On in_valid: load M=ext(a), A=0, Q=ext(b), q_m1=0, count=0;
//      go to RUN. is_signed is sampled only at this edge.
//    - RUN: in_ready=0. Each edge performs min(STEPS, N-count) chained Booth steps:
//      {Q[0],q_m1}=01 -> A+=M; =10 -> A-=M; =00/11 -> A unchanged (arithmetic is mod 2^N).
//      Then arithmetic right shift of {A,Q,q_m1} by 1, with A's MSB replicated.
//    - RUN occupies exactly C=ceil(N/STEPS) cycles. On the edge that completes step N:
//      z<={A,Q}[2*WIDTH-1:0]; go to DONE.
//    - DONE: out_valid=1; z is held stable. On out_ready: go to IDLE and clear out_valid.
//      z keeps its last value until the next result. A new input cannot be accepted in the
//      same cycle as the DONE->IDLE transition.
//  - Latency: operands accepted at edge k -> out_valid high after edge k+C.
//    W=8: STEPS=1 gives C=9; STEPS=3 gives C=3; STEPS=4 gives C=3 (last cycle does 1 step).
//  - in_valid while not IDLE is ignored; inputs may change freely outside the accept edge.
//  - out_ready while not DONE is ignored. Throughput is one product per C+2 cycles at best.
//  - The result is exact for all operands, including signed -2^(W-1) * -2^(W-1) and unsigned max*max.
// STRUCTURE
//  - Shared package/include booth_pkg:
//    - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2;
//    - function clog2;
//    - function cdiv(n,d) for C.
//  - Sub-module booth_step (combinational, N-bit):
//    - inputs: A, Q, q_m1, M, en; outputs: the next A, Q, q_m1.
//    - en=0 passes its inputs through unchanged.
//  - The top instantiates STEPS booth_step blocks in a generate chain. Step i has en=(count+i<N).
//  - The FSM and the count register sit in the top; count width is clog2(N+1).
// TESTING
//  1 W=8,S=1,signed: a=8'hFD(-3), b=8'h05 -> z=16'hFFF1; out_valid exactly 9 cycles after accept.
//  2 W=8,S=1,unsigned: a=8'hFF, b=8'hFF -> z=16'hFE01. Same operands, signed mode -> z=16'h0001.
//  3 W=8,S=4,signed: a=8'h80, b=8'h80 -> z=16'h4000 with C=3. a=8'h7F, b=8'h80 -> z=16'hC080.
//  4 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> z and out_valid stay stable,
//    in_ready stays 0, and an in_valid pulse during RUN/DONE is ignored.
//  5 Assert rst for 1 cycle at RUN cycle 4 -> next cycle IDLE, in_ready=1, out_valid=0, z=0.
//    A fresh 6*7 unsigned run then gives 16'h002A.
//  6 Random sweep: W in {4,8,16}, S in {1,2,3,W+1}, both modes. Compare against a reference
//    product and check C and the handshake timing.

Source files
------------

// File: rtl/booth_pkg.sv
// booth_pkg: shared FSM encoding and elaboration-time helpers for the Booth multiplier
package booth_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  function automatic int cdiv(input int n, input int d);
    return (n + d - 1) / d;
  endfunction
endpackage

// File: rtl/booth_step.sv
// booth_step: one radix-2 Booth add/subtract plus arithmetic right shift of {A,Q,q_m1}
module booth_step #(
  parameter int N = 9
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] q_i,
  input  logic         qm1_i,
  input  logic [N-1:0] m_i,
  input  logic         en_i,
  output logic [N-1:0] a_o,
  output logic [N-1:0] q_o,
  output logic         qm1_o
);
  logic [N-1:0] sum;
  always_comb begin
    sum = ({q_i[0], qm1_i} == 2'b01) ? a_i + m_i :
          ({q_i[0], qm1_i} == 2'b10) ? a_i - m_i : a_i;
    {a_o, q_o, qm1_o} = en_i ? {sum[N-1], sum, q_i} : {a_i, q_i, qm1_i};
  end
endmodule

// File: rtl/booth_seq_mult.sv
// booth_seq_mult: multi-cycle radix-2 Booth multiplier, STEPS chained steps per clock,
// valid/ready on both sides; operands are widened by one bit so unsigned mode is exact.
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEPS = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] z
);
  localparam int N = WIDTH + 1;
  localparam int CW = clog2(N + 1);
  state_e state_q, state_d;
  logic [N-1:0] m_q, m_d, a_q, a_d, q_q, q_d;
  logic qm1_q, qm1_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] z_q, z_d;
  logic [STEPS:0][N-1:0] ca, cq;
  logic [STEPS:0] cm;
  logic last;
  assign ca[0] = a_q;
  assign cq[0] = q_q;
  assign cm[0] = qm1_q;
  // Steps past N are disabled so the final cycle may do fewer than STEPS steps
  for (genvar i = 0; i < STEPS; i++) begin : g_step
    booth_step #(.N(N)) u_step (
      .a_i(ca[i]), .q_i(cq[i]), .qm1_i(cm[i]), .m_i(m_q),
      .en_i(int'(cnt_q) + i < N),
      .a_o(ca[i+1]), .q_o(cq[i+1]), .qm1_o(cm[i+1])
    );
  end
  assign last = int'(cnt_q) + STEPS >= N;
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign z = z_q;
  always_comb begin
    state_d = state_q;
    m_d = m_q;
    a_d = a_q;
    q_d = q_q;
    qm1_d = qm1_q;
    cnt_d = cnt_q;
    z_d = z_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        m_d = {is_signed & a[WIDTH-1], a};
        q_d = {is_signed & b[WIDTH-1], b};
        a_d = '0;
        qm1_d = 1'b0;
        cnt_d = '0;
        state_d = RUN;
      end
      RUN: begin
        a_d = ca[STEPS];
        q_d = cq[STEPS];
        qm1_d = cm[STEPS];
        cnt_d = last ? '0 : cnt_q + CW'(STEPS);
        z_d = last ? {ca[STEPS][WIDTH-2:0], cq[STEPS]} : z_q;
        state_d = last ? DONE : RUN;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q <= '0;
      a_q <= '0;
      q_q <= '0;
      qm1_q <= 1'b0;
      cnt_q <= '0;
      z_q <= '0;
    end else begin
      state_q <= state_d;
      m_q <= m_d;
      a_q <= a_d;
      q_q <= q_d;
      qm1_q <= qm1_d;
      cnt_q <= cnt_d;
      z_q <= z_d;
    end
  end
endmodule

// File: tb/tb_booth_seq_mult.sv
// tb_booth_seq_mult: directed checks on three configurations (W8/S1, W8/S4, W16/S3) driven in lockstep
module tb_booth_seq_mult;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, is_signed = 1'b0, out_ready = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic ir1, ir4, ir16, ov1, ov4, ov16;
  logic [15:0] z1, z4;
  logic [31:0] z16;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  booth_seq_mult #(.WIDTH(8), .STEPS(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .is_signed(is_signed),
    .a(a), .b(b), .out_valid(ov1), .out_ready(out_ready), .z(z1));
  booth_seq_mult #(.WIDTH(8), .STEPS(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4), .is_signed(is_signed),
    .a(a), .b(b), .out_valid(ov4), .out_ready(out_ready), .z(z4));
  booth_seq_mult #(.WIDTH(16), .STEPS(3)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16), .is_signed(is_signed),
    .a(a16), .b(b16), .out_valid(ov16), .out_ready(out_ready), .z(z16));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic idle_chk(input logic [15:0] e8, input logic [31:0] e16);
    chk("idle_ready", {ir1, ir4, ir16}, 3'b111);
    chk("idle_valid", {ov1, ov4, ov16}, 3'b000);
    chk("idle_z1", z1, e8);
    chk("idle_z4", z4, e8);
    chk("idle_z16", z16, e16);
  endtask
  // bp: pulse in_valid during RUN and during DONE, and hold out_ready low 5 extra cycles
  task automatic op(input logic sg, input logic [7:0] x, input logic [7:0] y,
                    input logic [15:0] x16, input logic [15:0] y16,
                    input logic [15:0] e8, input logic [31:0] e16, input bit bp);
    int l1, l4, l16;
    l1 = 0; l4 = 0; l16 = 0;
    @(negedge clk);
    is_signed = sg; a = x; b = y; a16 = x16; b16 = y16; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; is_signed = ~sg; a = ~x; b = ~y; a16 = ~x16; b16 = ~y16;
    for (int c = 1; c <= 12; c++) begin
      in_valid = bp && c == 2;
      @(posedge clk); #1;
      if (ov1 && l1 == 0) l1 = c;
      if (ov4 && l4 == 0) l4 = c;
      if (ov16 && l16 == 0) l16 = c;
    end
    in_valid = 1'b0;
    chk("lat_s1", l1, 9);
    chk("lat_s4", l4, 3);
    chk("lat_w16", l16, 6);
    chk("z_s1", z1, e8);
    chk("z_s4", z4, e8);
    chk("z_w16", z16, e16);
    chk("done_ready", {ir1, ir4, ir16}, 3'b000);
    if (bp) begin
      in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
        @(posedge clk); #1;
        chk("bp_valid", {ov1, ov4, ov16}, 3'b111);
        chk("bp_ready", {ir1, ir4, ir16}, 3'b000);
        chk("bp_z1", z1, e8);
        chk("bp_z16", z16, e16);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    idle_chk(e8, e16);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle_chk(16'h0000, 32'h0);
    op(1'b1, 8'hFD, 8'h05, 16'h8000, 16'h8000, 16'hFFF1, 32'h4000_0000, 1'b0);
    op(1'b0, 8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF, 16'hFE01, 32'hFFFE_0001, 1'b0);
    op(1'b1, 8'hFF, 8'hFF, 16'hFFFF, 16'h7FFF, 16'h0001, 32'hFFFF_8001, 1'b0);
    op(1'b1, 8'h80, 8'h80, 16'h0003, 16'h0005, 16'h4000, 32'h0000_000F, 1'b0);
    op(1'b0, 8'h0C, 8'h0B, 16'h8000, 16'h0002, 16'h0084, 32'h0001_0000, 1'b1);
    op(1'b1, 8'h7F, 8'h80, 16'hFFFE, 16'h0003, 16'hC080, 32'hFFFF_FFFA, 1'b0);
    @(negedge clk);
    is_signed = 1'b1; a = 8'h55; b = 8'h33; a16 = 16'h1234; b16 = 16'h0042; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_chk(16'h0000, 32'h0);
    @(posedge clk); #1;
    chk("post_rst_valid", {ov1, ov4, ov16}, 3'b000);
    op(1'b0, 8'h06, 8'h07, 16'h0006, 16'h0007, 16'h002A, 32'h0000_002A, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
